// File: rtl/adma_data_fifo.sv
// First-word-fall-through word buffer between the ADMA engine and the SD data path.
// Status outputs decode the registered level only; flush and reset clear everything.
module adma_data_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_L,
    input  logic                  fifo_write,
    input  logic [DATA_WIDTH-1:0] data_to_fifo,
    input  logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] data_from_fifo,
    input  logic                  fifo_flush,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AF_LVL   = (DEPTH_LOG2+1)'(AF_LEVEL);
    localparam logic [DEPTH_LOG2:0] AE_LVL   = (DEPTH_LOG2+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  ovf;
    logic                  unf;
    logic                  push_ok;
    logic                  pop_ok;

    assign fifo_full         = (level == FULL_LVL);
    assign fifo_empty        = (level == '0);
    assign fifo_almost_full  = (level >= AF_LVL);
    assign fifo_almost_empty = (level <= AE_LVL);
    assign fifo_level        = level;
    assign fifo_overflow     = ovf;
    assign fifo_underflow    = unf;

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    assign push_ok = fifo_write && (!fifo_full || fifo_read);
    assign pop_ok  = fifo_read && !fifo_empty;

    assign data_from_fifo = fifo_empty ? '0 : mem[rptr];

    always_ff @(posedge CLK) begin
        if (push_ok && !fifo_flush) begin
            mem[wptr] <= data_to_fifo;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (fifo_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level <= level - 1'b1;
            end
            if (fifo_write && fifo_full && !fifo_read) begin
                ovf <= 1'b1;
            end
            if (fifo_read && fifo_empty) begin
                unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adma_data_fifo.sv
// Directed bench for adma_data_fifo: fill/drain, full and empty corner cases,
// overflow/underflow, pointer wrap, flush priority and asynchronous reset.
module tb_adma_data_fifo;

    logic        CLK = 1'b0;
    logic        RESET_L;
    logic        fifo_write;
    logic [31:0] data_to_fifo;
    logic        fifo_read;
    logic [31:0] data_from_fifo;
    logic        fifo_flush;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_almost_full;
    logic        fifo_almost_empty;
    logic [4:0]  fifo_level;
    logic        fifo_overflow;
    logic        fifo_underflow;

    int tests = 0;
    int fails = 0;

    adma_data_fifo #(
        .DATA_WIDTH(32),
        .DEPTH_LOG2(4),
        .AF_LEVEL(12),
        .AE_LEVEL(4)
    ) dut (
        .CLK(CLK),
        .RESET_L(RESET_L),
        .fifo_write(fifo_write),
        .data_to_fifo(data_to_fifo),
        .fifo_read(fifo_read),
        .data_from_fifo(data_from_fifo),
        .fifo_flush(fifo_flush),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_almost_full(fifo_almost_full),
        .fifo_almost_empty(fifo_almost_empty),
        .fifo_level(fifo_level),
        .fifo_overflow(fifo_overflow),
        .fifo_underflow(fifo_underflow)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        fifo_write   = 1'b0;
        fifo_read    = 1'b0;
        fifo_flush   = 1'b0;
        data_to_fifo = 32'h0;
    endtask

    task automatic do_flush();
        idle_inputs();
        fifo_flush = 1'b1;
        step();
        fifo_flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET_L = 1'b0;
        #12;
        RESET_L = 1'b1;
        repeat (3) step();
        tests++;
        if (fifo_empty !== 1'b1) begin
            fails++;
            $display("FAIL reset_empty got %b want 1", fifo_empty);
        end
        tests++;
        if (fifo_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_full got %b want 0", fifo_full);
        end
        tests++;
        if (fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL reset_level got %0d want 0", fifo_level);
        end
        tests++;
        if (fifo_almost_empty !== 1'b1 || fifo_almost_full !== 1'b0) begin
            fails++;
            $display("FAIL reset_almost got ae=%b af=%b want ae=1 af=0",
                     fifo_almost_empty, fifo_almost_full);
        end
        tests++;
        if (data_from_fifo !== 32'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0", data_from_fifo);
        end
        tests++;
        if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_sticky got ov=%b un=%b want 0 0",
                     fifo_overflow, fifo_underflow);
        end
    endtask

    task automatic test_fill_drain();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            fifo_write   = 1'b1;
            data_to_fifo = 32'h1000_0000 + i;
            step();
            tests++;
            if (fifo_level !== 5'(i + 1)) begin
                fails++;
                $display("FAIL fill_level[%0d] got %0d want %0d",
                         i, fifo_level, i + 1);
            end
            tests++;
            if (fifo_almost_full !== (i + 1 >= 12)
                || fifo_full !== (i + 1 == 16)) begin
                fails++;
                $display("FAIL fill_flags[%0d] got af=%b full=%b want af=%b full=%b",
                         i, fifo_almost_full, fifo_full,
                         (i + 1 >= 12), (i + 1 == 16));
            end
        end
        fifo_write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fifo_read = 1'b1;
            #1;
            tests++;
            if (data_from_fifo !== 32'h1000_0000 + i) begin
                fails++;
                $display("FAIL drain_data[%0d] got %h want %h",
                         i, data_from_fifo, 32'h1000_0000 + i);
            end
            tests++;
            if (fifo_empty !== 1'b0) begin
                fails++;
                $display("FAIL drain_not_empty[%0d] got %b want 0",
                         i, fifo_empty);
            end
            step();
        end
        fifo_read = 1'b0;
        tests++;
        if (fifo_empty !== 1'b1 || fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL drain_end got empty=%b level=%0d want 1 0",
                     fifo_empty, fifo_level);
        end
    endtask

    task automatic test_full_rw_overflow();
        logic [31:0] exp;
        do_flush();
        for (int i = 0; i < 16; i++) begin
            fifo_write   = 1'b1;
            data_to_fifo = 32'h2000_0000 + i;
            step();
        end
        fifo_read    = 1'b1;
        data_to_fifo = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (data_from_fifo !== 32'h2000_0000) begin
            fails++;
            $display("FAIL full_rw_head got %h want 20000000", data_from_fifo);
        end
        step();
        tests++;
        if (fifo_level !== 5'd16 || fifo_overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_rw got level=%0d ov=%b want 16 0",
                     fifo_level, fifo_overflow);
        end
        fifo_read    = 1'b0;
        data_to_fifo = 32'hAAAA_AAAA;
        step();
        tests++;
        if (fifo_level !== 5'd16 || fifo_overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow got level=%0d ov=%b want 16 1",
                     fifo_level, fifo_overflow);
        end
        fifo_write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 32'hDEAD_BEEF : 32'h2000_0001 + i;
            fifo_read = 1'b1;
            #1;
            tests++;
            if (data_from_fifo !== exp) begin
                fails++;
                $display("FAIL full_drain[%0d] got %h want %h",
                         i, data_from_fifo, exp);
            end
            step();
        end
        tests++;
        if (fifo_level !== 5'd0 || fifo_underflow !== 1'b0
            || fifo_overflow !== 1'b1) begin
            fails++;
            $display("FAIL after_drain got level=%0d un=%b ov=%b want 0 0 1",
                     fifo_level, fifo_underflow, fifo_overflow);
        end
        step();
        fifo_read = 1'b0;
        tests++;
        if (fifo_level !== 5'd0 || fifo_underflow !== 1'b1) begin
            fails++;
            $display("FAIL underflow got level=%0d un=%b want 0 1",
                     fifo_level, fifo_underflow);
        end
    endtask

    task automatic test_empty_rw();
        do_flush();
        fifo_write   = 1'b1;
        fifo_read    = 1'b1;
        data_to_fifo = 32'h5555_5555;
        step();
        idle_inputs();
        tests++;
        if (fifo_level !== 5'd1 || data_from_fifo !== 32'h5555_5555
            || fifo_underflow !== 1'b1) begin
            fails++;
            $display("FAIL empty_rw got level=%0d data=%h un=%b want 1 55555555 1",
                     fifo_level, data_from_fifo, fifo_underflow);
        end
    endtask

    task automatic test_wrap();
        int wr = 0;
        int rd = 0;
        int lvl = 0;
        bit do_push;
        bit do_pop;
        do_flush();
        for (int cyc = 0; cyc < 200 && rd < 40; cyc++) begin
            if (wr >= 40) begin
                do_push = 1'b0;
                do_pop  = 1'b1;
            end else if (lvl < 3) begin
                do_push = 1'b1;
                do_pop  = 1'b0;
            end else begin
                do_push = (cyc % 3) != 2;
                do_pop  = (cyc % 3) != 0;
            end
            fifo_write   = do_push;
            data_to_fifo = 32'h3000_0000 + wr;
            fifo_read    = do_pop;
            #1;
            if (do_pop) begin
                tests++;
                if (data_from_fifo !== 32'h3000_0000 + rd) begin
                    fails++;
                    $display("FAIL wrap_data[%0d] got %h want %h",
                             rd, data_from_fifo, 32'h3000_0000 + rd);
                end
                rd++;
                lvl--;
            end
            if (do_push) begin
                wr++;
                lvl++;
            end
            step();
            if (lvl > 7 || (wr < 40 && wr > 3 && lvl < 3)) begin
                tests++;
                fails++;
                $display("FAIL wrap_range level %0d outside 3..7", lvl);
            end
            tests++;
            if (fifo_level !== 5'(lvl)) begin
                fails++;
                $display("FAIL wrap_level got %0d want %0d", fifo_level, lvl);
            end
        end
        idle_inputs();
        tests++;
        if (rd != 40) begin
            fails++;
            $display("FAIL wrap_budget got %0d words want 40", rd);
        end
    endtask

    task automatic test_flush();
        do_flush();
        fifo_read = 1'b1;
        step();
        fifo_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fifo_write   = 1'b1;
            data_to_fifo = 32'h4000_0000 + i;
            step();
        end
        tests++;
        if (fifo_level !== 5'd5 || fifo_underflow !== 1'b1) begin
            fails++;
            $display("FAIL pre_flush got level=%0d un=%b want 5 1",
                     fifo_level, fifo_underflow);
        end
        fifo_flush   = 1'b1;
        data_to_fifo = 32'h4444_4444;
        step();
        idle_inputs();
        tests++;
        if (fifo_level !== 5'd0 || fifo_empty !== 1'b1
            || fifo_underflow !== 1'b0 || fifo_overflow !== 1'b0) begin
            fails++;
            $display("FAIL flush got level=%0d empty=%b un=%b ov=%b want 0 1 0 0",
                     fifo_level, fifo_empty, fifo_underflow, fifo_overflow);
        end
        step();
        tests++;
        if (fifo_level !== 5'd0 || data_from_fifo !== 32'h0) begin
            fails++;
            $display("FAIL flush_hold got level=%0d data=%h want 0 0",
                     fifo_level, data_from_fifo);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            fifo_write   = 1'b1;
            data_to_fifo = 32'h6000_0000 + i;
            step();
        end
        #2;
        RESET_L = 1'b0;
        #1;
        tests++;
        if (fifo_empty !== 1'b1 || fifo_level !== 5'd0
            || data_from_fifo !== 32'h0) begin
            fails++;
            $display("FAIL async_reset got empty=%b level=%0d data=%h want 1 0 0",
                     fifo_empty, fifo_level, data_from_fifo);
        end
        idle_inputs();
        step();
        RESET_L = 1'b1;
        step();
        tests++;
        if (fifo_level !== 5'd0) begin
            fails++;
            $display("FAIL post_reset got level=%0d want 0", fifo_level);
        end
    endtask

    initial begin
        RESET_L = 1'b0;
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_full_rw_overflow();
        test_empty_rw();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adma_data_fifo.md
Name: adma_data_fifo

Overview:
- Word buffer on the FIFO side of the ADMA transfer engine.
- The engine pushes words here on RAM->card transfers, and pops words on card->RAM transfers. The SD data-line logic occupies the opposite port.
- It is the FIFO responder for the engine's fifo_read/fifo_write/fifo_full/fifo_empty interface.
- It is first-word-fall-through (FWFT): the head word is visible combinationally, so the engine can consume it in the same cycle it asserts fifo_read.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- DEPTH_LOG2, 4, log2 of the number of entries (default 16 words).
- AF_LEVEL, 12, fifo_almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 4, fifo_almost_empty asserts when level <= AE_LEVEL.

Ports:
- CLK  in  1  system clock, all state updates on the rising edge.
- RESET_L  in  1  asynchronous active-low reset.
- fifo_write  in  1  push request.
- data_to_fifo  in  DATA_WIDTH  word to push.
- fifo_read  in  1  pop request.
- data_from_fifo  out  DATA_WIDTH  current head word.
- fifo_flush  in  1  synchronous clear.
- fifo_full  out  1  level == 2^DEPTH_LOG2.
- fifo_empty  out  1  level == 0.
- fifo_almost_full  out  1  level >= AF_LEVEL.
- fifo_almost_empty  out  1  level <= AE_LEVEL.
- fifo_level  out  DEPTH_LOG2+1  number of stored words.
- fifo_overflow  out  1  sticky: a push was dropped.
- fifo_underflow  out  1  sticky: a pop on empty was ignored.

Behaviour:
- Reset (RESET_L low, asynchronous):
  - Pointers, level, overflow and underflow clear to 0.
  - Outputs: fifo_empty=1, fifo_full=0, fifo_almost_empty=1, fifo_almost_full=0, data_from_fifo=0.
  - Storage array is not reset.
  - Reset asserted mid-transfer discards all contents immediately, with no clock edge required.
- Storage and pointers:
  - Storage is 2^DEPTH_LOG2 x DATA_WIDTH.
  - Write pointer wptr and read pointer rptr are each DEPTH_LOG2 bits and wrap modulo depth.
  - level is a separate DEPTH_LOG2+1 bit register.
- Derived outputs: full, empty, almost_full, almost_empty and fifo_level are decoded from the registered level only. They change only after a clock edge and never combinationally from the request inputs.
- data_from_fifo (FWFT):
  - Equals mem[rptr] whenever level > 0, and 0 when empty.
  - A word pushed at edge N is visible on data_from_fifo after edge N if the FIFO was empty. Read-to-data latency is therefore 0 cycles; write-to-visible latency is 1 cycle.
- Effective operations per edge:
  - push_ok = fifo_write && (!full || fifo_read).
  - pop_ok = fifo_read && !empty.
- Push: writes data_to_fifo to mem[wptr], then wptr+1.
- Pop: rptr+1.
- Level update:
  - Push only: level+1.
  - Pop only: level-1.
  - Both, or neither: level unchanged.
- Full with simultaneous read and write: both succeed, level stays at depth, and no overflow is flagged.
- Empty with simultaneous read and write: only the push succeeds, level becomes 1, and underflow is set. The pop is not bypassed to the incoming word.
- Overflow: fifo_write && full && !fifo_read. The word is dropped, and fifo_overflow sets and stays 1.
- Underflow: fifo_read && empty. The pop is ignored, and fifo_underflow sets and stays 1.
- Flush (fifo_flush=1 at an edge):
  - Pointers, level and both sticky flags clear.
  - Flush has priority over any read or write in the same cycle; the write is discarded and is not flagged.
- Sticky flags clear only on reset or flush.
- No state machine beyond pointer/level tracking. Control is a per-edge priority decode: reset > flush > push/pop.

Test Plan:
- Reset then idle: RESET_L low, release, 3 CLK edges -> empty=1, full=0, level=0, almost_empty=1, data_from_fifo=0, both sticky flags=0.
- Fill 16 words 0x1000_0000+i, then drain 16 with fifo_read=1 each cycle:
  - data_from_fifo presents 0x1000_0000..0x1000_000F in order, each in the cycle its pop is asserted.
  - During the fill, almost_full rises when level reaches 12 and full rises at 16.
  - During the drain, empty returns after the 16th pop.
- Full plus simultaneous read/write: at level 16, pop and push 0xDEAD_BEEF in one cycle -> level stays 16, overflow=0. 0xDEAD_BEEF emerges as the 16th word on draining.
- Overflow/underflow:
  - Push 0xAAAA_AAAA while full with no read -> level stays 16, overflow=1, and the word never appears on drain.
  - Pop while empty -> underflow=1, level stays 0.
- Empty plus simultaneous read/write: at level 0, push 0x5555_5555 with fifo_read=1 -> after the edge level=1, data_from_fifo=0x5555_5555, underflow=1.
- Wrap, flush and async reset:
  - Push/pop 40 words interleaved at level 3..7 -> data stays in order across pointer wrap.
  - Flush at level 5 with a concurrent write -> level=0, empty=1, flags cleared.
  - Drop RESET_L mid-burst between edges -> empty=1 and level=0 immediately, before the next edge.
